// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words written to imem from address 0 (trailing XOR checksum with IMEM_LOADER_CHECKSUM_EN).
// Latency: 4 accepted bytes + 1 write cycle per word; done pulses the cycle after the last write (or after the checksum byte).
// Backpressure: in_ready is high only in LOAD/CSUM, so the source stalls during WRITE, DONE and IDLE.
module imem_loader #(
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  load_words,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  words_loaded,
   output logic              err
);

   localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CSUM, S_DONE} state_t;
   localparam state_t S_AFTER_LAST = S_CSUM;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
   localparam state_t S_AFTER_LAST = S_DONE;
`endif

   typedef struct packed {
      logic [CNT_W-1:0]  n_words;
      logic [CNT_W-1:0]  cnt;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        byte_idx;
      logic [31:0]       word;
   } ctx_t;

   state_t           state_q, state_d;
   ctx_t             ctx_q, ctx_d;
   logic             hold_q;
   logic             xfer;
   logic [CNT_W-1:0] n_clamped;
   logic [CNT_W-1:0] cnt_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   logic       err_q, err_d;
`endif

   assign xfer      = in_valid && in_ready;
   assign n_clamped = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
   assign cnt_inc   = ctx_q.cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ctx_q   <= '0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctx_q   <= ctx_d;
         hold_q  <= (state_q != S_IDLE);
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= 8'h00;
         err_q  <= 1'b0;
      end else begin
         csum_q <= csum_d;
         err_q  <= err_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      ctx_d   = ctx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ctx_d         = '0;
               ctx_d.n_words = n_clamped;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d        = 8'h00;
               err_d         = 1'b0;
`endif
               // An empty image still goes through the tail so a checksum byte is consumed.
               state_d = (n_clamped == '0) ? S_AFTER_LAST : S_LOAD;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               ctx_d.word[{ctx_q.byte_idx, 3'b000} +: 8] = in_data;
               ctx_d.byte_idx = ctx_q.byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ in_data;
`endif
               if (ctx_q.byte_idx == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // addr wraps to 0 after word 63; no write is issued for the wrapped value.
            ctx_d.addr = ctx_q.addr + 1'b1;
            ctx_d.cnt  = cnt_inc;
            state_d    = (cnt_inc == ctx_q.n_words) ? S_AFTER_LAST : S_LOAD;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (xfer) begin
               if (in_data != csum_q) begin
                  err_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign in_ready = (state_q == S_LOAD) || (state_q == S_CSUM);
   assign err      = err_q;
`else
   assign in_ready = (state_q == S_LOAD);
   assign err      = 1'b0;
`endif

   assign imem_we      = (state_q == S_WRITE);
   assign imem_addr    = ctx_q.addr;
   assign imem_wdata   = ctx_q.word;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign words_loaded = ctx_q.cnt;
   // hold_q stretches the hold one cycle past DONE; busy covers the first LOAD cycle.
   assign cpu_hold     = busy || hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-list model predicts every imem write, completion count and hold/err timing.
module tb_imem_loader;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 7;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  load_words = '0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  words_loaded;
   logic              err;

   imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .load_words(load_words),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .words_loaded(words_loaded), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  stim[$];
   wr_t         exp_q[$];
   logic [31:0] cap_mem[64];
   logic [31:0] saved[4];
   int          exp_n = 0;
   int          wr_load = 0;
   int          csum_sel = -1;
   bit          exp_err = 0;
   bit          m_active = 0;
   bit          m_tail = 0;
   bit          m_err = 0;
   bit          done_seen = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          done_cyc = 0;
   int          first_wr_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: expectations come from the byte list and load request, never from DUT state.
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst_n && start && !m_active) begin
            m_active  = 1;
            m_tail    = 0;
            m_err     = 0;
            wr_load   = 0;
            start_cyc = cyc;
         end
         @(negedge clk);
         if (!rst_n) begin
            m_active = 0;
            m_tail   = 0;
            m_err    = 0;
         end else begin
            chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, m_active || m_tail});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            if (!m_active) chk("in_ready_idle", {31'd0, in_ready}, 32'd0);
            if (imem_we) begin
               wr_load++;
               if (wr_load == 1) first_wr_cyc = cyc;
               cap_mem[imem_addr] = imem_wdata;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", imem_addr, imem_wdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_addr", {26'd0, imem_addr}, {26'd0, e.addr});
                  chk("wr_data", imem_wdata, e.data);
               end
            end
            if (done) begin
               chk("done_while_loading", {31'd0, m_active}, 32'd1);
               chk("words_loaded", {25'd0, words_loaded}, exp_n);
               chk("write_count", wr_load, exp_n);
               chk("writes_pending", exp_q.size(), 0);
               m_err     = exp_err;
               done_seen = 1;
               done_cyc  = cyc;
            end
            chk("err", {31'd0, err}, {31'd0, (done || !m_active) ? m_err : 1'b0});
            if (done) begin
               m_active = 0;
               m_tail   = 1;
            end else begin
               m_tail = 0;
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic send_byte(input logic [7:0] b);
      bit rdy;
      bit acc;
      acc = 0;
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 60 && !acc; t++) begin
         rdy = in_ready;
         @(posedge clk);
         acc = rdy;
         @(negedge clk);
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL byte_accept_timeout: byte 0x%0h not accepted in 60 cycles, required acceptance", b);
      end
   endtask

   task automatic run_load(input int nreq, input bit stall);
      int         n;
      logic [7:0] x;
      logic [7:0] csb;
      wr_t        w;
      n = (nreq > 64) ? 64 : nreq;
      exp_n = n;
      exp_q.delete();
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         w.addr = ADDR_W'(i);
         w.data = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
         exp_q.push_back(w);
         x = x ^ stim[4*i] ^ stim[4*i+1] ^ stim[4*i+2] ^ stim[4*i+3];
      end
      csb = (csum_sel < 0) ? x : csum_sel[7:0];
      exp_err = (CS == 1) && (csb != x);
      done_seen = 0;
      @(negedge clk);
      load_words = CNT_W'(nreq);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4*n; i++) begin
         if (stall && (i < 8 || i >= 16) && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         if (stall && i == 5) begin
            // start while busy must be ignored
            in_valid = 1'b0;
            load_words = 7'd1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         send_byte(stim[i]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(csb);
`endif
      in_valid = 1'b0;
      for (int t = 0; t < 300 && !done_seen; t++) begin
         @(negedge clk);
         #1;
      end
      if (!done_seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no done pulse within 300 cycles, required one");
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_addr", {26'd0, imem_addr}, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_words", {25'd0, words_loaded}, 32'd0);
      #1 rst_n = 1'b1;

      // Idle in_valid pulses must not be consumed.
      in_data = 8'hAA;
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b1;
         @(negedge clk);
         chk("idle_ready", {31'd0, in_ready}, 32'd0);
         in_valid = 1'b0;
      end

      // Two-word directed load.
      stim = '{8'h83, 8'h20, 8'h00, 8'h00, 8'h03, 8'hA1, 8'h40, 8'h00};
      run_load(2, 0);
      chk("lit_word0", cap_mem[0], 32'h00002083);
      chk("lit_word1", cap_mem[1], 32'h0040A103);
      chk("first_write_lat", first_wr_cyc - start_cyc, 4);
      chk("done_lat_2w", done_cyc - start_cyc, 10 + CS);
      @(negedge clk);
      chk("hold_after_done", {31'd0, cpu_hold}, 32'd1);
      @(negedge clk);
      chk("hold_released", {31'd0, cpu_hold}, 32'd0);

      // Stall-free vs. stalled runs of the same 4-word image.
      stim.delete();
      for (int i = 0; i < 16; i++) stim.push_back(8'((i * 37 + 5) & 8'hFF));
      run_load(4, 0);
      for (int i = 0; i < 4; i++) saved[i] = cap_mem[i];
      for (int i = 0; i < 4; i++) cap_mem[i] = 32'hDEAD_0000;
      run_load(4, 1);
      for (int i = 0; i < 4; i++) chk("stall_same_word", cap_mem[i], saved[i]);

      // Full-depth load, then clamped request.
      stim.delete();
      for (int i = 0; i < 256; i++) stim.push_back(8'(i));
      run_load(64, 0);
      chk("lit_full_w0", cap_mem[0], 32'h03020100);
      chk("lit_full_w63", cap_mem[63], 32'hFFFEFDFC);
      chk("addr_wrapped", {26'd0, imem_addr}, 32'd0);
      stim.delete();
      for (int i = 0; i < 256; i++) stim.push_back(8'(255 - i));
      run_load(100, 0);
      chk("lit_clamp_w0", cap_mem[0], 32'hFCFDFEFF);
      chk("lit_clamp_w63", cap_mem[63], 32'h00010203);
      chk("lit_clamp_count", {25'd0, words_loaded}, 32'd64);

      // Empty load.
      run_load(0, 0);
      chk("done_lat_empty", done_cyc - start_cyc, CS);
      chk("empty_no_writes", wr_load, 0);

      // Reset after 5 bytes of a 2-word load.
      stim = '{8'h83, 8'h20, 8'h00, 8'h00, 8'h03, 8'hA1, 8'h40, 8'h00};
      exp_q.delete();
      exp_q.push_back('{addr: 6'd0, data: 32'h00002083});
      exp_n = 2;
      @(negedge clk);
      load_words = 7'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(stim[i]);
      in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
      chk("mid_rst_words", {25'd0, words_loaded}, 32'd0);
      chk("mid_rst_addr", {26'd0, imem_addr}, 32'd0);
      chk("mid_rst_wdata", imem_wdata, 32'd0);
      chk("mid_rst_writes", wr_load, 1);
      chk("mid_rst_pending", exp_q.size(), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_load(1, 0);
      chk("reload_w0", cap_mem[0], 32'hEFBEADDE);

`ifdef IMEM_LOADER_CHECKSUM_EN
      stim = '{8'h11, 8'h22, 8'h44, 8'h88};
      csum_sel = 8'hFF;
      run_load(1, 0);
      chk("csum_good_err", {31'd0, err}, 32'd0);
      csum_sel = 8'hFE;
      run_load(1, 0);
      chk("csum_bad_err", {31'd0, err}, 32'd1);
      repeat (3) @(negedge clk);
      chk("csum_err_sticky", {31'd0, err}, 32'd1);
      csum_sel = -1;
      run_load(1, 0);
      chk("csum_err_cleared", {31'd0, err}, 32'd0);
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded 40000 cycles, required completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
